// File: rtl/peripheral_mpi_pkg.sv
// Shared definitions for the MPI peripheral Wishbone driver: register map,
// status bits, command opcodes and the sequencing FSM states.
package peripheral_mpi_pkg;

  localparam logic [31:0] MPI_REG_DATA   = 32'h0;
  localparam logic [31:0] MPI_REG_STATUS = 32'h4;

  localparam int MPI_STAT_RX_PEND  = 0;
  localparam int MPI_STAT_TX_SPACE = 1;

  localparam logic MPI_OP_SEND = 1'b0;
  localparam logic MPI_OP_RECV = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_HDR,
    ST_DATA,
    ST_FIN
  } mpi_state_e;

endpackage

// File: rtl/peripheral_mpi_wb_cycle.sv
// Single-transfer Wishbone engine: launches one classic cycle on start and
// terminates it on ack, err or after TIMEOUT cycles without a response.
module peripheral_mpi_wb_cycle #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tmo;

  // Abort on the cycle where the count of cycles with stb high reaches TIMEOUT.
  assign tmo   = cyc_q & ~wb_ack_i & ~wb_err_i & (tcnt_q == TW'(TIMEOUT - 1));
  assign done  = (cyc_q & (wb_ack_i | wb_err_i)) | tmo;
  assign err   = (cyc_q & wb_err_i) | tmo;
  assign rdata = wb_dat_i;
  assign busy  = cyc_q;

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

  always_comb begin
    cyc_d  = cyc_q;
    we_d   = we_q;
    adr_d  = adr_q;
    dat_d  = dat_q;
    tcnt_d = tcnt_q;
    if (!cyc_q) begin
      if (start) begin
        cyc_d  = 1'b1;
        we_d   = we;
        adr_d  = adr;
        dat_d  = dat;
        tcnt_d = '0;
      end
    end else if (done) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = '0;
      dat_d = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      tcnt_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      we_q   <= we_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      tcnt_q <= tcnt_d;
    end
  end

endmodule

// File: rtl/peripheral_mpi_wb_driver.sv
// Wishbone initiator for the MPI peripheral: turns send/receive commands into
// STATUS polling, header and payload transfers through the cycle engine.
module peripheral_mpi_wb_driver
  import peripheral_mpi_pkg::*;
#(
  parameter int          SIZE      = 16,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [$clog2(SIZE+1)-1:0]  cmd_len,
  input  logic [31:0]                tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [31:0]                rx_data,
  output logic                       rx_valid,
  output logic                       rx_last,
  input  logic                       rx_ready,
  output logic                       done,
  output logic                       err,
  output logic [31:0]                wb_adr_o,
  output logic [31:0]                wb_dat_o,
  output logic                       wb_we_o,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  input  logic [31:0]                wb_dat_i,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i
);

  localparam int          LW       = $clog2(SIZE + 1);
  localparam logic [31:0] ADR_DATA = ADDR_BASE + MPI_REG_DATA;
  localparam logic [31:0] ADR_STAT = ADDR_BASE + MPI_REG_STATUS;

  mpi_state_e    state_q, state_d;
  logic          op_q, op_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          eflag_q, eflag_d;
  logic          init_q;
  logic [31:0]   rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_last_q, rx_last_d;

  logic          eng_start, eng_we, eng_busy, eng_done, eng_err;
  logic [31:0]   eng_adr, eng_dat, eng_rdata;

  peripheral_mpi_wb_cycle #(.TIMEOUT(TIMEOUT)) u_cycle (
    .clk      (clk),
    .rst      (rst),
    .start    (eng_start),
    .we       (eng_we),
    .adr      (eng_adr),
    .dat      (eng_dat),
    .busy     (eng_busy),
    .done     (eng_done),
    .err      (eng_err),
    .rdata    (eng_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  // init_q keeps cmd_ready low through the first cycle after reset release.
  assign cmd_ready = (state_q == ST_IDLE) & init_q;
  assign done      = (state_q == ST_FIN);
  assign err       = (state_q == ST_FIN) & eflag_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_last   = rx_last_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    eflag_d    = eflag_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_last_d  = rx_last_q;
    eng_start  = 1'b0;
    eng_we     = 1'b0;
    eng_adr    = ADR_STAT;
    eng_dat    = '0;
    tx_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && init_q) begin
          op_d    = cmd_op;
          len_d   = cmd_len;
          cnt_d   = '0;
          eflag_d = 1'b0;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        eng_start = ~eng_busy;
        if (eng_done) begin
          if (eng_err) begin
            eflag_d = 1'b1;
            state_d = ST_FIN;
          end else if ((op_q == MPI_OP_SEND) ? eng_rdata[MPI_STAT_TX_SPACE]
                                             : eng_rdata[MPI_STAT_RX_PEND]) begin
            state_d = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        eng_start = ~eng_busy;
        eng_adr   = ADR_DATA;
        eng_we    = (op_q == MPI_OP_SEND);
        eng_dat   = 32'(len_q);
        cnt_d     = '0;
        if (eng_done) begin
          if (eng_err) begin
            eflag_d = 1'b1;
            state_d = ST_FIN;
          end else if (op_q == MPI_OP_SEND) begin
            state_d = (len_q == '0) ? ST_FIN : ST_DATA;
          end else if (eng_rdata == '0) begin
            state_d = ST_FIN;
          end else if (eng_rdata > 32'(SIZE)) begin
            eflag_d = 1'b1;
            state_d = ST_FIN;
          end else begin
            len_d   = LW'(eng_rdata);
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        eng_adr = ADR_DATA;
        if (op_q == MPI_OP_SEND) begin
          eng_we    = 1'b1;
          eng_dat   = tx_data;
          eng_start = ~eng_busy & tx_valid;
          if (eng_done) begin
            if (eng_err) begin
              eflag_d = 1'b1;
              state_d = ST_FIN;
            end else begin
              tx_ready = 1'b1;
              cnt_d    = cnt_q + LW'(1);
              if (cnt_q == len_q - LW'(1)) state_d = ST_FIN;
            end
          end
        end else begin
          // Skid register: no new read while a beat is still waiting on rx.
          eng_start = ~eng_busy & ~rx_valid_q & (cnt_q != len_q);
          if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
            rx_last_d  = 1'b0;
            if (rx_last_q) state_d = ST_FIN;
          end
          if (eng_done) begin
            if (eng_err) begin
              eflag_d = 1'b1;
              state_d = ST_FIN;
            end else begin
              rx_data_d  = eng_rdata;
              rx_valid_d = 1'b1;
              rx_last_d  = (cnt_q == len_q - LW'(1));
              cnt_d      = cnt_q + LW'(1);
            end
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= MPI_OP_SEND;
      len_q      <= '0;
      cnt_q      <= '0;
      eflag_q    <= 1'b0;
      init_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      eflag_q    <= eflag_d;
      init_q     <= 1'b1;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_last_q  <= rx_last_d;
    end
  end

endmodule
